// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared AES-128 constants, round-constant table and the
//            key-schedule state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

   // AES-128: 10 rounds, 128-bit round keys
   localparam int NR   = 10;
   localparam int RK_W = 128;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } key_sched_state_t;

   // Round constant for rounds 1..10; other indices never reach the datapath
   function automatic logic [7:0] rcon(input logic [3:0] round);
      logic [7:0] r;
      case (round)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/g.sv
`default_nettype none
// ============================================================================
// Module   : g
// Brief    : AES key-expansion word transform: RotWord, SubWord, then the
//            round constant XORed into the top byte. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module g
   import aes_pkg::*;
(
   output logic [31:0] out,
   input  logic [31:0] in,
   input  logic [3:0]  iflag
);

   // Forward S-box, entry 0 in the most significant byte
   localparam logic [0:255][7:0] c_sbox = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // RotWord moves byte 0 to the bottom; rcon lands on the new top byte
   assign out = {c_sbox[in[23:16]] ^ rcon(iflag),
                 c_sbox[in[15:8]],
                 c_sbox[in[7:0]],
                 c_sbox[in[31:24]]};

endmodule
`default_nettype wire

// File: rtl/key_sched.sv
`default_nettype none
// ============================================================================
// Module   : key_sched
// Brief    : Iterative AES-128 key-schedule sequencer. Emits round keys 0..10
//            as a valid/ready stream, one new key per accepted transfer.
//            Optional macro KEY_SCHED_STORE_EN adds an 11-entry key store
//            with a combinational read port for reverse-order use.
// Revision : 1.0 - initial release
// ============================================================================
module key_sched
   import aes_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [RK_W-1:0] key_in,
   output logic            busy,
   output logic            rk_valid,
   input  logic            rk_ready,
   output logic [3:0]      rk_round,
   output logic [RK_W-1:0] rk_out,
   output logic            done,
   input  logic [3:0]      rd_idx,
   output logic [RK_W-1:0] rd_key,
   output logic            keys_stored
);

   key_sched_state_t r_state;

   logic [31:0]     w_t;
   logic [31:0]     w_n0, w_n1, w_n2, w_n3;
   logic [RK_W-1:0] w_next;
   logic [3:0]      w_iflag;
   logic            w_xfer;
   logic            w_start_acc;
   logic            w_last;

   assign w_xfer      = rk_valid & rk_ready;
   assign w_start_acc = (r_state == IDLE) & start;
   assign w_last      = (rk_round == 4'(NR));
   assign w_iflag     = rk_round + 4'd1;

   g u_g (
      .out   (w_t),
      .in    (rk_out[31:0]),
      .iflag (w_iflag)
   );

   // Whole next round key in one cycle from the registered current key
   assign w_n0   = rk_out[127:96] ^ w_t;
   assign w_n1   = w_n0 ^ rk_out[95:64];
   assign w_n2   = w_n1 ^ rk_out[63:32];
   assign w_n3   = w_n2 ^ rk_out[31:0];
   assign w_next = {w_n0, w_n1, w_n2, w_n3};

   // Sequencer: load key on start, advance on each transfer, retire after round 10
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         busy     <= 1'b0;
         rk_valid <= 1'b0;
         rk_round <= 4'd0;
         rk_out   <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state  <= RUN;
                  rk_out   <= key_in;
                  rk_round <= 4'd0;
                  rk_valid <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               if (w_xfer) begin
                  if (w_last) begin
                     r_state  <= IDLE;
                     rk_valid <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     rk_out   <= w_next;
                     rk_round <= rk_round + 4'd1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef KEY_SCHED_STORE_EN
   logic [RK_W-1:0] r_store [0:NR];

   // Capture every transferred key at its round index; reset discards all
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= NR; i++) r_store[i] <= '0;
      end else if (w_xfer) begin
         r_store[rk_round] <= rk_out;
      end
   end

   // Flag a complete set; a new schedule invalidates it but keeps contents
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         keys_stored <= 1'b0;
      end else if (w_start_acc) begin
         keys_stored <= 1'b0;
      end else if (w_xfer && w_last) begin
         keys_stored <= 1'b1;
      end
   end

   assign rd_key = (rd_idx <= 4'(NR)) ? r_store[rd_idx] : '0;
`else
   logic w_unused_rd;

   assign w_unused_rd = ^{rd_idx, w_start_acc};
   assign rd_key      = '0;
   assign keys_stored = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/key_sched.md
# key_sched

Iterative AES-128 key-schedule sequencer that produces the 11 round keys, rounds 0..10, as a valid/ready stream. It feeds the cipher datapath's AddRoundKey stage, and it drives the existing `g` word-transform module with the last word of the current round key and the round index. One round key is produced per accepted transfer, and the consumer can apply backpressure.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin a new schedule; sampled only in IDLE
- `key_in`  in  128  cipher key, word 0 in bits [127:96]; captured on accepted `start`
- `busy`  out  1  high from accepted `start` until final transfer completes
- `rk_valid`  out  1  `rk_out`/`rk_round` hold a round key
- `rk_ready`  in  1  consumer accepts; transfer = `rk_valid & rk_ready`
- `rk_round`  out  4  round index 0..10 of `rk_out`
- `rk_out`  out  128  round key, same word order as `key_in`
- `done`  out  1  one-cycle pulse the cycle after the round-10 transfer
- `rd_idx`  in  4  stored-key read index (see Configuration)
- `rd_key`  out  128  stored round key at `rd_idx`
- `keys_stored`  out  1  all 11 keys held in store

## Operation
- FSM states: IDLE, RUN.
  - IDLE: `start` → RUN. `key_in` loads into `rk_out`, `rk_round`=0, `rk_valid`=1, `busy`=1.
  - RUN without a transfer: all outputs hold. `rk_out` and `rk_round` stay stable while `rk_valid & !rk_ready`.
  - RUN, transfer with `rk_round`<10: the next key loads and `rk_round` increments. `rk_valid` stays 1, so back-to-back transfers are possible.
  - RUN, transfer with `rk_round`=10: go to IDLE. `rk_valid`=0 and `busy`=0 next cycle, and `done` pulses that cycle.
- `start` while in RUN is ignored. A `start` asserted in the same cycle that returns to IDLE is also ignored; it is sampled the following cycle.
- Next-key arithmetic. Words are w0..w3 = `rk_out` from MSB down; r = `rk_round`+1.
  - t = g(w3, r): RotWord, then SubWord, then rcon(r) XORed into the MSB byte.
  - rcon(1..10) = 01,02,04,08,10,20,40,80,1B,36.
  - n0 = w0^t, n1 = n0^w1, n2 = n1^w2, n3 = n2^w3. All 32-bit XOR, no carries.
- `g` is purely combinational. The full round computes in one cycle from registered `rk_out`, with no extra latency.
- Reset mid-schedule: abort immediately to IDLE. Any partial store contents are discarded.

## Timing
- Reset values: `busy`=0, `rk_valid`=0, `rk_round`=0, `rk_out`=0, `done`=0, `keys_stored`=0, `rd_key`=0.
- Start acceptance: `start` accepted at edge N → round 0 valid from N+1.
- With `rk_ready` held high: round k is valid in cycle N+1+k, and round 10 at N+11. `done` pulses at N+12, and a new `start` is accepted at edge N+12 at the earliest.
- Stall: each cycle of `rk_ready`=0 delays all later rounds by one cycle.
- Output timing: all outputs are registered except `rd_key`, which is a combinational read.

## Configuration
- `KEY_SCHED_STORE_EN` defined:
  - An 11×128 register store captures `rk_out` at index `rk_round` on every transfer.
  - `keys_stored` sets on the round-10 transfer. It clears on accepted `start` or `rst`; store contents are not cleared.
  - `rd_key` = store[`rd_idx`] for `rd_idx` ≤ 10, and 0 for `rd_idx` > 10. This serves decryption's reverse-order key use.
- Not defined: no store is built. `rd_key` is tied to 0 and `keys_stored` to 0, and `rd_idx` is ignored.

## Structure
- Shared package `aes_pkg`:
  - `NR`=10 and `RK_W`=128.
  - rcon table function `rcon(round)`.
  - State enum `key_sched_state_t` {IDLE, RUN}.
- Sub-module: one instance of the existing `g` (`out`, `in`, `iflag`). `iflag` is driven with `rk_round`+1 and is only meaningful for values 1..10.

## Test plan
- FIPS-197 A.1 key `2b7e151628aed2a6abf7158809cf4f3c`, `rk_ready`=1:
  - round 1 = `a0fafe1788542cb123a339392a6c7605`
  - round 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6`
  - round 10 at N+11, `done` at N+12
- All-zero key:
  - round 1 = `62636363626363636263636362636363`
  - round 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`
- Backpressure: random `rk_ready` (≈50%) → same 11 keys in order. `rk_out` and `rk_round` stable during every stall. Exactly 11 transfers, one `done`.
- Start while busy: `start` pulsed with a different key at round 5 → ignored; schedule completes with the original key.
- Reset at round 4 → next cycle `rk_valid`=0, `busy`=0, `rk_out`=0. A fresh `start` then produces a correct round 0..10 sequence.
- With `KEY_SCHED_STORE_EN`, after the A.1 run:
  - `rd_idx`=10 → `d014f9a8…0ca6`, `rd_idx`=0 → key, `rd_idx`=12 → 0
  - `keys_stored`=1, and it clears on the next `start`
